sd_receive: RTL and testbench
=============================

Name: sd_receive

Overview:
Serial response receiver for the SD host controller's command line, downstream of sd_send. Armed once sd_send finishes a command token. Waits for the card's start bit, shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response, and checks framing and CRC7. Presents the decoded fields with a one-cycle valid pulse to the command-sequencing FSM.

Parameters:
TIMEOUT_CYCLES, 64, max sd_clk cycles from arm to start bit (NCR limit); counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
sd_clk  input  1  sole clock; sd_cmd is sampled on posedge.
reset  input  1  asynchronous, active-low reset.
rx_en  input  1  one-cycle arm pulse; ignored while busy=1.
resp_type  input  2  latched at arm: 0=48-bit with CRC, 1=48-bit no CRC (R3), 2=136-bit R2, 3=treated as 0.
exp_idx  input  6  expected command index, latched at arm.
sd_cmd  input  1  serial response line, idle high.
busy  output  1  high from the cycle after arm until resp_valid or timeout.
resp_valid  output  1  one-cycle completion pulse.
resp_idx  output  6  received bits [45:40] (48-bit) or 6'h3F field (R2).
resp_data  output  120  48-bit: {88'b0, arg[31:0]}; R2: bits [127:8] of CID/CSD.
crc_err  output  1  valid with resp_valid.
frame_err  output  1  valid with resp_valid: transmission bit !=0 or end bit !=1.
idx_err  output  1  see Optional Feature.
timeout  output  1  one-cycle pulse; no start bit within TIMEOUT_CYCLES.

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0; shift register, counters and CRC cleared.
- States: IDLE -> WAIT_START -> RECEIVE -> DONE -> IDLE.
- IDLE: on rx_en=1, latch resp_type and exp_idx, clear the cycle counter and go to WAIT_START.
- WAIT_START: each posedge, a sample of sd_cmd=0 is the start bit; go to RECEIVE with bit counter = frame length-1 (47 or 135).
- WAIT_START: otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES with no start bit, pulse timeout and return to IDLE; resp_valid stays 0.
- A start bit sampled on the same edge the counter reaches TIMEOUT_CYCLES wins; no timeout.
- RECEIVE: shift one bit per posedge, MSB first, and decrement the bit counter. The end bit is the sample taken at counter=1.
- DONE: one cycle after the end-bit sample, assert resp_valid with every field and flag; busy drops the same cycle; next state IDLE.
- Latency: arm-to-first-sample is 1 cycle; resp_valid comes 1 cycle after the end-bit edge.
- CRC7 (x^7+x^3+1, init 0), 48-bit frames: covers bits 47..8. 136-bit frames: covers bits 127..8 only; the 8 header bits are excluded. Compare with bits 7..1. For resp_type 1, crc_err is forced 0.
- frame_err: transmission bit (bit 46 / bit 134) must be 0 and the end bit must be 1.
- Errors never suppress resp_valid; data is always delivered.
- rx_en during busy: ignored, no re-arm.
- Outputs resp_idx/resp_data/flags hold their values until the next resp_valid or reset.
- Reset mid-frame: immediate IDLE, no resp_valid.

Optional Feature:
SD_RX_IDX_CHECK_EN
- Defined: for resp_type 0 only, idx_err = (resp_idx != exp_idx), reported with resp_valid. R1/R6/R7 echo the index.
- Undefined: idx_err is tied 0. exp_idx is still a port and is left unused.

Decomposition:
- Shared package sd_pkg: RESP_LEN_48=48, RESP_LEN_136=136, resp_type encodings (RESP_48_CRC, RESP_48_NOCRC, RESP_136), state encodings, CRC7 polynomial constant.
- One sub-module, sd_crc7_serial: bit-serial CRC7 with clear/enable/data_in and a 7-bit result. It is the same primitive sd_send uses, so it must be shared rather than duplicated.

Test Plan:
- R7 for CMD8: arm resp_type=0, exp_idx=8; idle 5 cycles; drive 48'h08_000001AA_xx with the CRC7 byte from the bench model. Require resp_valid=1, resp_idx=8, resp_data=32'h000001AA, crc_err=frame_err=idx_err=0. The pulse lands exactly 54 cycles after arm: 1 arm-to-first-sample + 5 idle + 48 frame bits.
- R3 OCR: resp_type=1, drive 48'h3F_80FF8000_FF. Require resp_data=32'h80FF8000 and crc_err=0 even though the CRC field is 7'h7F.
- R2 CID: resp_type=2, 136-bit frame with a correct CRC7. Require resp_idx=6'h3F, resp_data equal to frame bits [127:8], crc_err=0. Repeat with one payload bit flipped: require crc_err=1 and resp_valid still pulsed.
- Timeout: arm and hold sd_cmd=1. Require timeout pulse exactly TIMEOUT_CYCLES=64 cycles after arm, resp_valid never set, busy=0 afterwards. Repeat with start bit on cycle 64: require no timeout.
- Framing/index: transmission bit=1 -> frame_err=1; end bit=0 -> frame_err=1. With SD_RX_IDX_CHECK_EN, a response index of 17 with exp_idx=8 -> idx_err=1.
- Robustness: assert reset at bit 20 of a frame -> busy=0 and all outputs 0 immediately, no resp_valid. A second rx_en while busy -> single resp_valid only.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared SD host definitions: response lengths, response-type and receiver
// state encodings, and the CRC7 (x^7+x^3+1) single-bit update.
package sd_pkg;

  localparam int unsigned RESP_LEN_48  = 48;
  localparam int unsigned RESP_LEN_136 = 136;
  localparam logic [6:0]  CRC7_POLY    = 7'h09;

  typedef enum logic [1:0] {
    RESP_48_CRC   = 2'd0,
    RESP_48_NOCRC = 2'd1,
    RESP_136      = 2'd2
  } resp_type_e;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    RECEIVE    = 2'd2,
    DONE       = 2'd3
  } rx_state_e;

  // Encoding 3 is reserved and behaves like a plain 48-bit CRC response.
  function automatic resp_type_e decode_resp_type(input logic [1:0] code);
    resp_type_e t;
    case (code)
      2'd1:    t = RESP_48_NOCRC;
      2'd2:    t = RESP_136;
      default: t = RESP_48_CRC;
    endcase
    return t;
  endfunction

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_receive_if.sv
// Command-line response bus between the command sequencer (master) and the
// response receiver (slave); sd_cmd is carried here as the card's line.
interface sd_receive_if;

  logic         rx_en;
  logic [1:0]   resp_type;
  logic [5:0]   exp_idx;
  logic         sd_cmd;
  logic         busy;
  logic         resp_valid;
  logic [5:0]   resp_idx;
  logic [119:0] resp_data;
  logic         crc_err;
  logic         frame_err;
  logic         idx_err;
  logic         timeout;

  modport master (
    output rx_en, resp_type, exp_idx, sd_cmd,
    input  busy, resp_valid, resp_idx, resp_data,
    input  crc_err, frame_err, idx_err, timeout
  );

  modport slave (
    input  rx_en, resp_type, exp_idx, sd_cmd,
    output busy, resp_valid, resp_idx, resp_data,
    output crc_err, frame_err, idx_err, timeout
  );

endinterface

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 generator shared by the SD command transmitter and receiver.
module sd_crc7_serial
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       data_in,
  output logic [6:0] crc
);

  logic [6:0] crc_r;

  // CRC state: clear has priority over a data bit in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc_r <= 7'h00;
    end else if (clear) begin
      crc_r <= 7'h00;
    end else if (enable) begin
      crc_r <= crc7_step(crc_r, data_in);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/sd_receive.sv
// SD command-line response receiver (48-bit and 136-bit frames, CRC7 and framing).
// Optional build macro SD_RX_IDX_CHECK_EN enables command-index echo checking.
module sd_receive
  import sd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic         sd_clk,
  input logic         reset,
  sd_receive_if.slave rx
);

  localparam int unsigned TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  LAST_48  = 8'(RESP_LEN_48 - 1);
  localparam logic [7:0]  LAST_136 = 8'(RESP_LEN_136 - 1);

  rx_state_e    state_r;
  resp_type_e   type_r;
  logic [TW-1:0] wait_cnt_r;
  logic [7:0]   bit_cnt_r;
  logic [134:0] sr_r;
  logic         busy_r;
  logic         resp_valid_r;
  logic [5:0]   resp_idx_r;
  logic [119:0] resp_data_r;
  logic         crc_err_r;
  logic         frame_err_r;
  logic         idx_err_r;
  logic         timeout_r;
`ifdef SD_RX_IDX_CHECK_EN
  logic [5:0]   exp_idx_r;
`endif

  logic [6:0]   crc_s;
  logic         crc_clr_s;
  logic         crc_en_s;
  logic [5:0]   dec_idx_s;
  logic [119:0] dec_data_s;
  logic         dec_crc_err_s;
  logic         dec_frame_err_s;
  logic         dec_idx_err_s;

  // CRC gating: the start bit seeds 48-bit frames; R2 skips its 8-bit header.
  // In RECEIVE the bit being sampled is bit_cnt_r-1, so bits 127..8 map to 128..9.
  always_comb begin
    crc_clr_s = (state_r == IDLE) && rx.rx_en;
    crc_en_s  = 1'b0;
    if (state_r == WAIT_START) begin
      crc_en_s = (rx.sd_cmd == 1'b0) && (type_r != RESP_136);
    end else if (state_r == RECEIVE) begin
      crc_en_s = (bit_cnt_r >= 8'd9) && (bit_cnt_r <= 8'd128);
    end else begin
      crc_en_s = 1'b0;
    end
  end

  sd_crc7_serial u_crc7 (
    .clk     (sd_clk),
    .reset   (reset),
    .clear   (crc_clr_s),
    .enable  (crc_en_s),
    .data_in (rx.sd_cmd),
    .crc     (crc_s)
  );

  // Field decode from the completed frame held in the shift register
  always_comb begin
    dec_idx_s       = 6'd0;
    dec_data_s      = 120'd0;
    dec_frame_err_s = 1'b0;
    if (type_r == RESP_136) begin
      dec_idx_s       = sr_r[133:128];
      dec_data_s      = sr_r[127:8];
      dec_frame_err_s = sr_r[134] | ~sr_r[0];
    end else begin
      dec_idx_s       = sr_r[45:40];
      dec_data_s      = {88'd0, sr_r[39:8]};
      dec_frame_err_s = sr_r[46] | ~sr_r[0];
    end
    if (type_r == RESP_48_NOCRC) begin
      dec_crc_err_s = 1'b0;
    end else begin
      dec_crc_err_s = (crc_s != sr_r[7:1]);
    end
`ifdef SD_RX_IDX_CHECK_EN
    dec_idx_err_s = (type_r == RESP_48_CRC) && (dec_idx_s != exp_idx_r);
`else
    dec_idx_err_s = 1'b0;
`endif
  end

  // Receive sequencer: arm, start-bit search with NCR timeout, shifting, result capture
  always_ff @(posedge sd_clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      type_r       <= RESP_48_CRC;
      wait_cnt_r   <= '0;
      bit_cnt_r    <= 8'd0;
      sr_r         <= 135'd0;
      busy_r       <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_idx_r   <= 6'd0;
      resp_data_r  <= 120'd0;
      crc_err_r    <= 1'b0;
      frame_err_r  <= 1'b0;
      idx_err_r    <= 1'b0;
      timeout_r    <= 1'b0;
`ifdef SD_RX_IDX_CHECK_EN
      exp_idx_r    <= 6'd0;
`endif
    end else begin
      resp_valid_r <= 1'b0;
      timeout_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rx.rx_en) begin
            type_r     <= decode_resp_type(rx.resp_type);
`ifdef SD_RX_IDX_CHECK_EN
            exp_idx_r  <= rx.exp_idx;
`endif
            wait_cnt_r <= '0;
            sr_r       <= 135'd0;
            busy_r     <= 1'b1;
            state_r    <= WAIT_START;
          end else begin
            busy_r     <= 1'b0;
          end
        end
        WAIT_START: begin
          // A start bit on the final allowed edge still wins over the timeout.
          if (rx.sd_cmd == 1'b0) begin
            bit_cnt_r <= (type_r == RESP_136) ? LAST_136 : LAST_48;
            sr_r      <= {sr_r[133:0], rx.sd_cmd};
            state_r   <= RECEIVE;
          end else if (wait_cnt_r == TO_LAST) begin
            timeout_r <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + TW'(1);
          end
        end
        RECEIVE: begin
          sr_r      <= {sr_r[133:0], rx.sd_cmd};
          bit_cnt_r <= bit_cnt_r - 8'd1;
          if (bit_cnt_r == 8'd1) begin
            state_r <= DONE;
          end else begin
            state_r <= RECEIVE;
          end
        end
        DONE: begin
          resp_valid_r <= 1'b1;
          resp_idx_r   <= dec_idx_s;
          resp_data_r  <= dec_data_s;
          crc_err_r    <= dec_crc_err_s;
          frame_err_r  <= dec_frame_err_s;
          idx_err_r    <= dec_idx_err_s;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign rx.busy       = busy_r;
  assign rx.resp_valid = resp_valid_r;
  assign rx.resp_idx   = resp_idx_r;
  assign rx.resp_data  = resp_data_r;
  assign rx.crc_err    = crc_err_r;
  assign rx.frame_err  = frame_err_r;
  assign rx.idx_err    = idx_err_r;
  assign rx.timeout    = timeout_r;

endmodule

// File: tb/tb_sd_receive.sv
// Directed bench for sd_receive: a frame-level model predicts every response
// and the cycle it lands on; a negedge monitor compares the DUT against it.
module tb_sd_receive;

  logic sd_clk;
  logic reset;
  sd_receive_if bus ();

  sd_receive #(.TIMEOUT_CYCLES(64)) dut (
    .sd_clk (sd_clk),
    .reset  (reset),
    .rx     (bus)
  );

  initial begin
    sd_clk = 1'b0;
    forever #5 sd_clk = ~sd_clk;
  end

  int cyc = 0;
  always @(posedge sd_clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // model state: expected event cycles and expected response contents
  int m_valid_cyc = -1;
  int m_to_cyc = -1;
  int m_busy_lo = 0;
  int m_busy_hi = 0;
  logic [5:0]   e_idx;
  logic [119:0] e_data;
  logic         e_crc, e_frm, e_ie;
  int arm_cyc = 0;
  int last_valid_cyc = -1;
  int last_to_cyc = -1;
  int valid_count = 0;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // CRC7 as the remainder of msg(x)*x^7 divided by x^7+x^3+1 (long division)
  function automatic logic [6:0] crc7_model(input logic [119:0] msg, input int n);
    logic [126:0] r;
    r = {msg, 7'b0};
    for (int i = n + 6; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [135:0] mk48(input logic [5:0] idx, input logic [31:0] arg,
                                        input logic trans, input logic endb);
    logic [39:0] h;
    h = {1'b0, trans, idx, arg};
    return 136'({h, crc7_model(120'(h), 40), endb});
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  136'(bus.busy), 136'd0);
    chk({tag, "_valid"}, 136'(bus.resp_valid), 136'd0);
    chk({tag, "_idx"},   136'(bus.resp_idx), 136'd0);
    chk({tag, "_data"},  136'(bus.resp_data), 136'd0);
    chk({tag, "_crc"},   136'(bus.crc_err), 136'd0);
    chk({tag, "_frm"},   136'(bus.frame_err), 136'd0);
    chk({tag, "_ie"},    136'(bus.idx_err), 136'd0);
    chk({tag, "_to"},    136'(bus.timeout), 136'd0);
  endtask

  // Monitor: every cycle busy/resp_valid/timeout follow the model; fields on resp_valid
  initial begin
    forever begin
      @(negedge sd_clk);
      chk("busy", 136'(bus.busy), 136'((cyc >= m_busy_lo) && (cyc < m_busy_hi)));
      chk("resp_valid", 136'(bus.resp_valid), 136'(cyc == m_valid_cyc));
      chk("timeout", 136'(bus.timeout), 136'(cyc == m_to_cyc));
      if (bus.resp_valid === 1'b1) begin
        last_valid_cyc = cyc;
        valid_count++;
      end
      if (bus.timeout === 1'b1) last_to_cyc = cyc;
      if (cyc == m_valid_cyc) begin
        chk("resp_idx", 136'(bus.resp_idx), 136'(e_idx));
        chk("resp_data", 136'(bus.resp_data), 136'(e_data));
        chk("crc_err", 136'(bus.crc_err), 136'(e_crc));
        chk("frame_err", 136'(bus.frame_err), 136'(e_frm));
        chk("idx_err", 136'(bus.idx_err), 136'(e_ie));
      end
    end
  end

  // Arm, idle for 'idle' samples, then shift the frame MSB first.
  // stray: extra rx_en (with a different type) while busy; abort_bits>0: reset mid-frame.
  task automatic run_frame(input logic [1:0] typ, input logic [5:0] eidx, input int idle,
                           input logic [135:0] f, input int len, input bit stray,
                           input int abort_bits);
    bit aborted;
    aborted = 1'b0;
    @(posedge sd_clk); #1;
    arm_cyc = cyc + 1;
    if (len == 48) begin
      e_idx  = f[45:40];
      e_data = {88'd0, f[39:8]};
      e_crc  = (typ != 2'd1) && (crc7_model(120'(f[47:8]), 40) != f[7:1]);
      e_frm  = f[46] | ~f[0];
    end else begin
      e_idx  = f[133:128];
      e_data = f[127:8];
      e_crc  = (crc7_model(f[127:8], 120) != f[7:1]);
      e_frm  = f[134] | ~f[0];
    end
`ifdef SD_RX_IDX_CHECK_EN
    e_ie = ((typ == 2'd0) || (typ == 2'd3)) && (len == 48) && (e_idx != eidx);
`else
    e_ie = 1'b0;
`endif
    m_valid_cyc = arm_cyc + idle + len + 1;
    m_busy_lo   = arm_cyc;
    m_busy_hi   = m_valid_cyc;
    m_to_cyc    = -1;
    bus.rx_en = 1'b1; bus.resp_type = typ; bus.exp_idx = eidx; bus.sd_cmd = 1'b1;
    @(posedge sd_clk); #1;
    bus.rx_en = 1'b0;
    for (int i = 0; i < idle; i++) begin
      bus.rx_en = stray && (i == 2);
      bus.resp_type = (stray && (i == 2)) ? 2'd2 : typ;
      bus.sd_cmd = 1'b1;
      @(posedge sd_clk); #1;
    end
    bus.rx_en = 1'b0;
    bus.resp_type = typ;
    for (int k = 0; k < len; k++) begin
      if (abort_bits > 0 && k == abort_bits) begin
        aborted = 1'b1;
        break;
      end
      bus.sd_cmd = f[len - 1 - k];
      if (stray && k == 10) bus.rx_en = 1'b1;
      else bus.rx_en = 1'b0;
      @(posedge sd_clk); #1;
    end
    bus.rx_en = 1'b0;
    if (aborted) begin
      m_valid_cyc = -1; m_busy_lo = 0; m_busy_hi = 0;
      reset = 1'b0;
      #1;
      chk_all_zero("abort");
      repeat (2) @(posedge sd_clk);
      #1;
      reset = 1'b1;
      bus.sd_cmd = 1'b1;
    end else begin
      bus.sd_cmd = 1'b1;
      @(posedge sd_clk);
      @(negedge sd_clk); #1;
    end
  endtask

  task automatic run_timeout(input int start_after);
    @(posedge sd_clk); #1;
    arm_cyc = cyc + 1;
    m_valid_cyc = -1; m_to_cyc = arm_cyc + 64; m_busy_lo = arm_cyc; m_busy_hi = arm_cyc + 64;
    bus.rx_en = 1'b1; bus.resp_type = 2'd0; bus.exp_idx = 6'd8; bus.sd_cmd = 1'b1;
    @(posedge sd_clk); #1;
    bus.rx_en = 1'b0;
    repeat (start_after) @(posedge sd_clk);
    #1;
  endtask

  logic [119:0] p2;
  logic [135:0] f2;
  int vc0, to0;

  initial begin
    reset = 1'b1;
    bus.rx_en = 1'b0; bus.resp_type = 2'd0; bus.exp_idx = 6'd0; bus.sd_cmd = 1'b1;
    #1 reset = 1'b0;
    #1 chk_all_zero("reset");
    repeat (3) @(posedge sd_clk);
    #1 reset = 1'b1;

    // model pins: well-known SD command CRC7 values (CMD0, CMD8 0x1AA, CMD17)
    chk("crc_pin_cmd0",  136'(crc7_model(120'h40_0000_0000, 40)), 136'h4A);
    chk("crc_pin_cmd8",  136'(crc7_model(120'h48_0000_01AA, 40)), 136'h43);
    chk("crc_pin_cmd17", 136'(crc7_model(120'h51_0000_0000, 40)), 136'h2A);

    // R7 for CMD8, 5 idle samples: resp_valid exactly 54 cycles after arm
    run_frame(2'd0, 6'd8, 5, mk48(6'd8, 32'h0000_01AA, 1'b0, 1'b1), 48, 1'b0, 0);
    chk("r7_latency", 136'(last_valid_cyc - arm_cyc), 136'd54);
    chk("r7_idx", 136'(bus.resp_idx), 136'd8);
    chk("r7_data", 136'(bus.resp_data), 136'h1AA);
    chk("r7_flags", 136'({bus.crc_err, bus.frame_err, bus.idx_err}), 136'd0);

    // R3 OCR: CRC field all ones, no CRC check
    run_frame(2'd1, 6'd0, 2, 136'h3F_80FF_8000_FF, 48, 1'b0, 0);
    chk("r3_data", 136'(bus.resp_data), 136'h80FF_8000);
    chk("r3_crc", 136'(bus.crc_err), 136'd0);

    // R2 CID with good CRC, then one payload bit flipped
    p2 = 120'h03_5344_5344_3332_3210_1234_5601_4A5B;
    f2 = {1'b0, 1'b0, 6'h3F, p2, crc7_model(p2, 120), 1'b1};
    run_frame(2'd2, 6'd0, 3, f2, 136, 1'b0, 0);
    chk("r2_idx", 136'(bus.resp_idx), 136'h3F);
    chk("r2_data", 136'(bus.resp_data), 136'(p2));
    chk("r2_crc", 136'(bus.crc_err), 136'd0);
    f2[60] = ~f2[60];
    run_frame(2'd2, 6'd0, 3, f2, 136, 1'b0, 0);
    chk("r2_bad_crc", 136'(bus.crc_err), 136'd1);
    chk("r2_bad_latency", 136'(last_valid_cyc - arm_cyc), 136'd140);

    // NCR timeout with the line held high
    vc0 = valid_count;
    run_timeout(70);
    chk("to_latency", 136'(last_to_cyc - arm_cyc), 136'd64);
    chk("to_busy", 136'(bus.busy), 136'd0);
    chk("to_no_valid", 136'(valid_count - vc0), 136'd0);

    // start bit sampled on the 64th cycle wins; type 3 behaves as type 0
    to0 = last_to_cyc;
    run_frame(2'd3, 6'd8, 63, mk48(6'd8, 32'h0000_0900, 1'b0, 1'b1), 48, 1'b0, 0);
    chk("late_start_no_to", 136'(last_to_cyc), 136'(to0));
    chk("late_start_latency", 136'(last_valid_cyc - arm_cyc), 136'd112);
    chk("late_start_crc", 136'(bus.crc_err), 136'd0);

    // framing errors
    run_frame(2'd0, 6'd8, 1, mk48(6'd8, 32'h1234_5678, 1'b1, 1'b1), 48, 1'b0, 0);
    chk("trans_bit_err", 136'(bus.frame_err), 136'd1);
    run_frame(2'd0, 6'd8, 1, mk48(6'd8, 32'h1234_5678, 1'b0, 1'b0), 48, 1'b0, 0);
    chk("end_bit_err", 136'(bus.frame_err), 136'd1);

    // index echo mismatch
    run_frame(2'd0, 6'd8, 4, mk48(6'd17, 32'hCAFE_0001, 1'b0, 1'b1), 48, 1'b0, 0);
    chk("idx17_idx", 136'(bus.resp_idx), 136'd17);
`ifdef SD_RX_IDX_CHECK_EN
    chk("idx17_err", 136'(bus.idx_err), 136'd1);
`else
    chk("idx17_err", 136'(bus.idx_err), 136'd0);
`endif

    // reset at bit 20, then no response may appear
    vc0 = valid_count;
    run_frame(2'd0, 6'd8, 0, mk48(6'd8, 32'hA5A5_5A5A, 1'b0, 1'b1), 48, 1'b0, 20);
    repeat (70) @(posedge sd_clk);
    #1;
    chk("abort_no_valid", 136'(valid_count - vc0), 136'd0);

    // rx_en pulses while busy are ignored: exactly one response
    vc0 = valid_count;
    run_frame(2'd0, 6'd8, 5, mk48(6'd8, 32'h0000_01AA, 1'b0, 1'b1), 48, 1'b1, 0);
    repeat (10) @(posedge sd_clk);
    #1;
    chk("double_arm_count", 136'(valid_count - vc0), 136'd1);

    repeat (3) @(posedge sd_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
